// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack, branch redirect and the
// valid/ready instruction stream toward decode.
interface fetch_if #(
  parameter int XLEN = 32
);
  logic            IFmem_req;
  logic [XLEN-1:0] IFmem_addr;
  logic            IFmem_ack;
  logic [XLEN-1:0] IFmem_rdata;
  logic            IFredirect;
  logic [XLEN-1:0] IFredirect_pc;
  logic            IFvalid;
  logic            IFready;
  logic [XLEN-1:0] IFinstruction;
  logic [XLEN-1:0] IFpc;
  logic [XLEN-1:0] IFpc_plus4;
  logic            IFmisaligned;

  modport master (
    output IFmem_req, IFmem_addr, IFvalid, IFinstruction, IFpc, IFpc_plus4, IFmisaligned,
    input  IFmem_ack, IFmem_rdata, IFredirect, IFredirect_pc, IFready
  );

  modport slave (
    input  IFmem_req, IFmem_addr, IFvalid, IFinstruction, IFpc, IFpc_plus4, IFmisaligned,
    output IFmem_ack, IFmem_rdata, IFredirect, IFredirect_pc, IFready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, requests words over req/ack,
// buffers them in a small prefetch FIFO and flushes on a redirect.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] fpc, fpc_next, drop_addr;
  logic [CNTW-1:0] count, count_next;
  logic [PTRW-1:0] rd_ptr, wr_ptr;
  logic            misaligned;
  logic            req, ack, redirect, push, pop, space, valid;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] inst_q [DEPTH];

  assign req      = (state != IDLE);
  assign ack      = bus.IFmem_ack & req;
  assign redirect = bus.IFredirect;
  assign valid    = (count != '0);
  assign push     = (state == WAIT) & ack & ~redirect;
  assign pop      = valid & bus.IFready & ~redirect;

  // Only request when the returning word is guaranteed a slot after this edge.
  always_comb begin
    count_next = count;
    if (redirect)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CNTW'(1);
    else if (pop && !push)
      count_next = count - CNTW'(1);
    space = (count_next < CNTW'(DEPTH));
  end

  always_comb begin
    state_next = state;
    fpc_next   = fpc;
    if (redirect)
      fpc_next = {bus.IFredirect_pc[XLEN-1:2], 2'b00};
    else if (push)
      fpc_next = fpc + XLEN'(4);
    case (state)
      IDLE: if (!redirect && space) state_next = WAIT;
      WAIT: begin
        if (redirect)
          state_next = ack ? IDLE : DROP;
        else if (ack)
          state_next = space ? WAIT : IDLE;
      end
      DROP: if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      fpc        <= RESET_PC;
      drop_addr  <= RESET_PC;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_next;
      fpc        <= fpc_next;
      count      <= count_next;
      misaligned <= redirect & (|bus.IFredirect_pc[1:0]);
      // The in-flight request must keep its original address until acked.
      if (state == WAIT && redirect && !ack)
        drop_addr <= fpc;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTRW'(1);
        if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_q[wr_ptr]   <= fpc;
      inst_q[wr_ptr] <= bus.IFmem_rdata;
    end
  end

  assign head_pc           = valid ? pc_q[rd_ptr] : '0;
  assign bus.IFmem_req     = req;
  assign bus.IFmem_addr    = (state == DROP) ? drop_addr : fpc;
  assign bus.IFvalid       = valid;
  assign bus.IFinstruction = valid ? inst_q[rd_ptr] : NOP;
  assign bus.IFpc          = head_pc;
  assign bus.IFpc_plus4    = head_pc + XLEN'(4);
  assign bus.IFmisaligned  = misaligned;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with configurable ack delay,
// hand-computed expectations checked with immediate assertions.
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   mem_delay;
  int   wait_cnt;
  logic force_ack;

  fetch_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responds on the falling edge so its ack is settled for the next rising edge.
  initial begin
    bus.IFmem_ack   = 1'b0;
    bus.IFmem_rdata = '0;
    wait_cnt        = 0;
    forever begin
      @(negedge clk);
      if (!reset || !bus.IFmem_req) wait_cnt = 0;
      if (mem_delay == 0) begin
        bus.IFmem_ack = bus.IFmem_req;
        wait_cnt      = 0;
      end else if (reset && bus.IFmem_req) begin
        wait_cnt = wait_cnt + 1;
        if (wait_cnt >= mem_delay) begin
          bus.IFmem_ack = 1'b1;
          wait_cnt      = 0;
        end else begin
          bus.IFmem_ack = 1'b0;
        end
      end else begin
        bus.IFmem_ack = 1'b0;
      end
      bus.IFmem_ack   = bus.IFmem_ack | force_ack;
      bus.IFmem_rdata = bus.IFmem_addr ^ KEY;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors = vectors + 1;
    assert (obs === expv) else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.IFvalid !== 1'b1 && n < budget) begin
      step();
      n = n + 1;
    end
    check_output(tag, 32'(bus.IFvalid), 32'd1);
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    mem_delay         = 0;
    force_ack         = 1'b0;
    reset             = 1'b0;
    bus.IFredirect    = 1'b0;
    bus.IFredirect_pc = '0;
    bus.IFready       = 1'b1;

    // Reset state and zero-wait streaming
    step();
    step();
    check_output("rst_req", 32'(bus.IFmem_req), 32'd0);
    check_output("rst_valid", 32'(bus.IFvalid), 32'd0);
    check_output("rst_mis", 32'(bus.IFmisaligned), 32'd0);
    check_output("rst_inst", bus.IFinstruction, 32'h0000_0013);
    check_output("rst_pc", bus.IFpc, 32'h0);
    check_output("rst_pc4", bus.IFpc_plus4, 32'h4);
    reset = 1'b1;
    step();
    check_output("s_req1", 32'(bus.IFmem_req), 32'd1);
    check_output("s_addr1", bus.IFmem_addr, 32'h0);
    check_output("s_valid1", 32'(bus.IFvalid), 32'd0);
    step();
    check_output("s_pc4_0", bus.IFpc_plus4, 32'h4);
    for (int i = 0; i < 6; i++) begin
      check_output("s_valid", 32'(bus.IFvalid), 32'd1);
      check_output("s_pc", bus.IFpc, 32'(4 * i));
      check_output("s_inst", bus.IFinstruction, 32'(4 * i) ^ KEY);
      step();
    end

    // Backpressure: two words buffered, request drops, head stable
    reset       = 1'b0;
    bus.IFready = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_output("bp_addr1", bus.IFmem_addr, 32'h0);
    step();
    check_output("bp_pc_e2", bus.IFpc, 32'h0);
    check_output("bp_addr2", bus.IFmem_addr, 32'h4);
    step();
    check_output("bp_req_e3", 32'(bus.IFmem_req), 32'd0);
    step();
    step();
    check_output("bp_req_hold", 32'(bus.IFmem_req), 32'd0);
    check_output("bp_valid_hold", 32'(bus.IFvalid), 32'd1);
    check_output("bp_pc_hold", bus.IFpc, 32'h0);
    check_output("bp_inst_hold", bus.IFinstruction, KEY);
    bus.IFready = 1'b1;
    step();
    check_output("bp_pc_r1", bus.IFpc, 32'h4);
    check_output("bp_addr_r1", bus.IFmem_addr, 32'h8);
    step();
    check_output("bp_pc_r2", bus.IFpc, 32'h8);
    step();
    check_output("bp_pc_r3", bus.IFpc, 32'hC);

    // Ack delayed by three cycles
    reset     = 1'b0;
    mem_delay = 3;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("d_addr_wait", bus.IFmem_addr, 32'h0);
      check_output("d_valid_wait", 32'(bus.IFvalid), 32'd0);
    end
    step();
    check_output("d_valid0", 32'(bus.IFvalid), 32'd1);
    check_output("d_pc0", bus.IFpc, 32'h0);
    check_output("d_addr4", bus.IFmem_addr, 32'h4);
    step();
    check_output("d_valid_pop", 32'(bus.IFvalid), 32'd0);
    step();
    check_output("d_addr4_hold", bus.IFmem_addr, 32'h4);
    step();
    check_output("d_pc4", bus.IFpc, 32'h4);
    step();
    check_output("d_one_push", 32'(bus.IFvalid), 32'd0);

    // Redirect while waiting without ack: old word dropped
    bus.IFredirect    = 1'b1;
    bus.IFredirect_pc = 32'h100;
    step();
    bus.IFredirect = 1'b0;
    check_output("dr_req", 32'(bus.IFmem_req), 32'd1);
    check_output("dr_addr_old", bus.IFmem_addr, 32'h8);
    check_output("dr_valid", 32'(bus.IFvalid), 32'd0);
    step();
    check_output("dr_req_idle", 32'(bus.IFmem_req), 32'd0);
    check_output("dr_valid_idle", 32'(bus.IFvalid), 32'd0);
    step();
    check_output("dr_new_addr", bus.IFmem_addr, 32'h100);
    wait_valid("dr_wait", 10);
    check_output("dr_pc", bus.IFpc, 32'h100);
    check_output("dr_inst", bus.IFinstruction, 32'h100 ^ KEY);

    // Misaligned redirect coinciding with an ack
    mem_delay = 0;
    step();
    check_output("ma_pre_pc", bus.IFpc, 32'h104);
    check_output("ma_pre_req", 32'(bus.IFmem_req), 32'd1);
    bus.IFredirect    = 1'b1;
    bus.IFredirect_pc = 32'h202;
    step();
    bus.IFredirect = 1'b0;
    check_output("ma_pulse", 32'(bus.IFmisaligned), 32'd1);
    check_output("ma_valid", 32'(bus.IFvalid), 32'd0);
    check_output("ma_req", 32'(bus.IFmem_req), 32'd0);
    step();
    check_output("ma_pulse_end", 32'(bus.IFmisaligned), 32'd0);
    check_output("ma_addr", bus.IFmem_addr, 32'h200);
    step();
    check_output("ma_pc", bus.IFpc, 32'h200);
    check_output("ma_inst", bus.IFinstruction, 32'h200 ^ KEY);
    check_output("ma_pc4", bus.IFpc_plus4, 32'h204);

    // PC wrap at the top of the address space
    bus.IFredirect    = 1'b1;
    bus.IFredirect_pc = 32'hFFFF_FFFC;
    step();
    bus.IFredirect = 1'b0;
    check_output("w_mis", 32'(bus.IFmisaligned), 32'd0);
    step();
    check_output("w_addr", bus.IFmem_addr, 32'hFFFF_FFFC);
    step();
    check_output("w_pc", bus.IFpc, 32'hFFFF_FFFC);
    check_output("w_pc4", bus.IFpc_plus4, 32'h0);
    check_output("w_addr_wrap", bus.IFmem_addr, 32'h0);
    step();
    check_output("w_pc_wrap", bus.IFpc, 32'h0);

    // Reset in the middle of a wait, with an ack landing during reset
    mem_delay = 3;
    step();
    check_output("rw_req", 32'(bus.IFmem_req), 32'd1);
    reset     = 1'b0;
    force_ack = 1'b1;
    step();
    check_output("rw_req_rst", 32'(bus.IFmem_req), 32'd0);
    check_output("rw_valid_rst", 32'(bus.IFvalid), 32'd0);
    step();
    reset     = 1'b1;
    force_ack = 1'b0;
    step();
    check_output("rw_addr", bus.IFmem_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_output("rw_no_stale", 32'(bus.IFvalid), 32'd0);
      step();
    end
    check_output("rw_valid", 32'(bus.IFvalid), 32'd1);
    check_output("rw_pc", bus.IFpc, 32'h0);
    check_output("rw_inst", bus.IFinstruction, KEY);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
